mem_port_arbiter: RTL and testbench

//  Shares the single data-memory/IO port of address_space between two requesters: port 0 = MIPS

---
 rtl/mem_port_arbiter.sv | 141 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - two-requester round-robin arbiter for the shared data-memory/IO port
//
// Purpose: port 0 (CPU datapath) and port 1 (loader/debug master) share one single-beat memory
// port. Each beat uses a req/gnt/ack handshake. Ties alternate between the two ports. Port 1 may
// lock the port for up to MAX_BURST consecutive beats.
//
// Ports:
//   i_clk, i_arst                      clock; asynchronous active-low reset
//   i_req0/i_we0/i_addr0/i_wdata0      port 0 request, write enable, address, write data
//   o_gnt0/o_ack0/o_rdata0/o_stall0    port 0 grant, completion pulse, read data, CPU freeze
//   i_req1/i_we1/i_addr1/i_wdata1      port 1 request, write enable, address, write data
//   i_lock1                            port 1 asks to keep ownership for a burst
//   o_gnt1/o_ack1/o_rdata1             port 1 grant, completion pulse, read data
//   o_mem_we/o_mem_addr/o_mem_wdata    memory side, driven from the current owner
//   i_mem_rdata                        combinational read data from memory
module mem_port_arbiter #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int MAX_BURST = 4
) (
    input  logic              i_clk,
    input  logic              i_arst,
    input  logic              i_req0,
    input  logic              i_we0,
    input  logic [ADDR_W-1:0] i_addr0,
    input  logic [DATA_W-1:0] i_wdata0,
    output logic              o_gnt0,
    output logic              o_ack0,
    output logic [DATA_W-1:0] o_rdata0,
    output logic              o_stall0,
    input  logic              i_req1,
    input  logic              i_we1,
    input  logic [ADDR_W-1:0] i_addr1,
    input  logic [DATA_W-1:0] i_wdata1,
    input  logic              i_lock1,
    output logic              o_gnt1,
    output logic              o_ack1,
    output logic [DATA_W-1:0] o_rdata1,
    output logic              o_mem_we,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [DATA_W-1:0] o_mem_wdata,
    input  logic [DATA_W-1:0] i_mem_rdata
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    localparam int CNT_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    // burst_cnt counts the extra locked beats after the first one.
    localparam logic [CNT_W-1:0] BURST_LAST = CNT_W'(MAX_BURST - 1);

    state_t            state, state_n;
    logic              last_grant, last_grant_n;
    logic [CNT_W-1:0]  burst_cnt, burst_cnt_n;

    logic              owner_req;
    logic              owner_we;
    logic [ADDR_W-1:0] owner_addr;
    logic [DATA_W-1:0] owner_wdata;

    // Memory-side mux. It decodes from the state register so that an asynchronous reset drops
    // o_mem_we immediately.
    always_comb begin
        owner_req   = 1'b0;
        owner_we    = 1'b0;
        owner_addr  = '0;
        owner_wdata = '0;
        case (state)
            OWN0: begin
                owner_req   = i_req0;
                owner_we    = i_we0;
                owner_addr  = i_addr0;
                owner_wdata = i_wdata0;
            end
            OWN1: begin
                owner_req   = i_req1;
                owner_we    = i_we1;
                owner_addr  = i_addr1;
                owner_wdata = i_wdata1;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_n      = IDLE;
        last_grant_n = last_grant;
        burst_cnt_n  = '0;
        if (state == OWN1 && i_lock1 && i_req1 && burst_cnt < BURST_LAST) begin
            state_n     = OWN1;
            burst_cnt_n = burst_cnt + 1'b1;
        end else if (i_req0 && i_req1) begin
            state_n = last_grant ? OWN0 : OWN1;
        end else if (i_req0) begin
            state_n = OWN0;
        end else if (i_req1) begin
            state_n = OWN1;
        end
        if (state_n == OWN0) begin
            last_grant_n = 1'b0;
        end else if (state_n == OWN1) begin
            last_grant_n = 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_arst) begin
        if (!i_arst) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            burst_cnt  <= '0;
            o_ack0     <= 1'b0;
            o_ack1     <= 1'b0;
            o_rdata0   <= '0;
            o_rdata1   <= '0;
        end else begin
            state      <= state_n;
            last_grant <= last_grant_n;
            burst_cnt  <= burst_cnt_n;
            // A beat completes only if the owner still requests at the end of its grant cycle.
            o_ack0     <= (state == OWN0) && i_req0;
            o_ack1     <= (state == OWN1) && i_req1;
            if (state == OWN0 && i_req0 && !i_we0) begin
                o_rdata0 <= i_mem_rdata;
            end
            if (state == OWN1 && i_req1 && !i_we1) begin
                o_rdata1 <= i_mem_rdata;
            end
        end
    end

    assign o_gnt0      = (state == OWN0);
    assign o_gnt1      = (state == OWN1);
    assign o_stall0    = i_req0 & ~o_gnt0;
    assign o_mem_we    = owner_we & owner_req;
    assign o_mem_addr  = owner_addr;
    assign o_mem_wdata = owner_wdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - scoreboard bench for mem_port_arbiter with a behavioural arbitration model
module tb_mem_port_arbiter;

    localparam int MB = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req0 = 1'b0, we0 = 1'b0, req1 = 1'b0, we1 = 1'b0, lock1 = 1'b0;
    logic [31:0] addr0 = '0, wdata0 = '0, addr1 = '0, wdata1 = '0;
    logic        gnt0, ack0, stall0, gnt1, ack1, mem_we;
    logic [31:0] rdata0, rdata1, mem_addr, mem_wdata, mem_rdata;
    logic [31:0] ram [64];

    int n_chk = 0;
    int n_err = 0;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_BURST(MB)) dut (
        .i_clk(clk), .i_arst(rst_n),
        .i_req0(req0), .i_we0(we0), .i_addr0(addr0), .i_wdata0(wdata0),
        .o_gnt0(gnt0), .o_ack0(ack0), .o_rdata0(rdata0), .o_stall0(stall0),
        .i_req1(req1), .i_we1(we1), .i_addr1(addr1), .i_wdata1(wdata1), .i_lock1(lock1),
        .o_gnt1(gnt1), .o_ack1(ack1), .o_rdata1(rdata1),
        .o_mem_we(mem_we), .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata),
        .i_mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] init_val(int i);
        if (i == 16) return 32'hDEADBEEF;
        return 32'h1000_0000 + 32'(i) * 32'h0101_0101;
    endfunction

    // Memory stand-in: combinational read, write at the clock edge, refilled while in reset.
    assign mem_rdata = ram[mem_addr[5:0]];
    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 64; i++) ram[i] <= init_val(i);
        end else if (mem_we) begin
            ram[mem_addr[5:0]] <= mem_wdata;
        end
    end

    task automatic chk_b(string nm, logic act, logic exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk_w(string nm, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: who owns the port next cycle, from the arbitration rules.
    typedef struct {
        bit          rd;
        logic [31:0] d;
    } exp_t;
    exp_t        q0[$], q1[$];
    int          m_own  = 0;   // 0 nobody, 1 port 0, 2 port 1
    int          m_last = 1;   // port that won most recently
    int          m_run  = 0;   // consecutive beats of the current port-1 ownership
    logic [31:0] shadow [64];

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_own = 0; m_last = 1; m_run = 0;
                q0.delete(); q1.delete();
                for (int i = 0; i < 64; i++) shadow[i] = init_val(i);
            end else begin
                if (m_own == 1 && req0) begin
                    q0.push_back('{rd: !we0, d: shadow[addr0[5:0]]});
                    if (we0) shadow[addr0[5:0]] = wdata0;
                end
                if (m_own == 2 && req1) begin
                    q1.push_back('{rd: !we1, d: shadow[addr1[5:0]]});
                    if (we1) shadow[addr1[5:0]] = wdata1;
                end
                if (m_own == 2 && lock1 && req1 && m_run < MB) begin
                    m_run++;
                end else begin
                    if (req0 && req1) m_own = (m_last == 0) ? 2 : 1;
                    else if (req0)    m_own = 1;
                    else if (req1)    m_own = 2;
                    else              m_own = 0;
                    if (m_own == 2) m_run = 1;
                    if (m_own != 0) m_last = m_own - 1;
                end
            end
        end
    end

    // Monitor: compares every cycle, pops the scoreboard whenever an ack is presented.
    logic [31:0] h0 = '0, h1 = '0;
    initial begin
        exp_t e;
        logic [31:0] e_addr, e_wdata;
        logic        e_we;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                h0 = '0; h1 = '0;
            end
            e_we = 1'b0; e_addr = '0; e_wdata = '0;
            if (m_own == 1) begin e_we = we0 & req0; e_addr = addr0; e_wdata = wdata0; end
            if (m_own == 2) begin e_we = we1 & req1; e_addr = addr1; e_wdata = wdata1; end
            chk_b("gnt0", gnt0, m_own == 1);
            chk_b("gnt1", gnt1, m_own == 2);
            chk_b("stall0", stall0, req0 && m_own != 1);
            chk_b("mem_we", mem_we, e_we);
            chk_w("mem_addr", mem_addr, e_addr);
            chk_w("mem_wdata", mem_wdata, e_wdata);
            chk_b("ack0", ack0, q0.size() != 0);
            chk_b("ack1", ack1, q1.size() != 0);
            if (q0.size() != 0) begin e = q0.pop_front(); if (e.rd) h0 = e.d; end
            if (q1.size() != 0) begin e = q1.pop_front(); if (e.rd) h1 = e.d; end
            chk_w("rdata0", rdata0, h0);
            chk_w("rdata1", rdata1, h1);
        end
    end

    logic        s_g0, s_g1, s_a0, s_a1, s_st, s_we;
    logic [31:0] s_addr, s_rd0;

    task automatic step();
        @(negedge clk);
        s_g0 = gnt0; s_g1 = gnt1; s_a0 = ack0; s_a1 = ack1; s_st = stall0;
        s_we = mem_we; s_addr = mem_addr; s_rd0 = rdata0;
        #1;
    endtask

    task automatic reset_pulse();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        int beats, waits;
        bit seen0;
        repeat (3) step();
        rst_n = 1'b1;

        // Idle after reset.
        for (int i = 0; i < 10; i++) begin
            step();
            chk_b("idle_gnt", s_g0 | s_g1, 1'b0);
            chk_b("idle_ack", s_a0 | s_a1, 1'b0);
            chk_b("idle_we", s_we, 1'b0);
            chk_w("idle_addr", s_addr, 32'h0);
        end

        // Single port-0 read of 0x10.
        req0 = 1'b1; we0 = 1'b0; addr0 = 32'h10;
        step();
        chk_b("rd_gnt0", s_g0, 1'b1);
        step();
        chk_b("rd_ack0", s_a0, 1'b1);
        chk_w("rd_data0", s_rd0, 32'hDEADBEEF);
        req0 = 1'b0;
        step(); step();

        // Port-1 write aborted by dropping req1 in the grant cycle.
        req1 = 1'b1; we1 = 1'b1; addr1 = 32'h20; wdata1 = 32'hA5;
        step();
        chk_b("abort_gnt1", s_g1, 1'b1);
        req1 = 1'b0;
        #1;
        chk_b("abort_we", mem_we, 1'b0);
        step();
        chk_b("abort_ack1", s_a1, 1'b0);
        step();
        chk_w("abort_ram", ram[32], init_val(32));
        we1 = 1'b0;

        // Both requesting continuously: strict alternation, port 0 first.
        reset_pulse();
        req0 = 1'b1; req1 = 1'b1; addr0 = 32'h4; addr1 = 32'h8;
        for (int i = 0; i < 4; i++) begin
            step();
            chk_b("rr_gnt0", s_g0, (i % 2) == 0);
            chk_b("rr_gnt1", s_g1, (i % 2) == 1);
            chk_b("rr_stall0", s_st, (i % 2) == 1);
        end
        req0 = 1'b0; req1 = 1'b0;
        step(); step();

        // Locked burst on port 1, port 0 arrives in the second cycle.
        reset_pulse();
        beats = 0; waits = 0; seen0 = 0;
        req1 = 1'b1; lock1 = 1'b1;
        step(); if (s_g1) beats++;
        step(); if (s_g1) beats++;
        req0 = 1'b1;
        #1;
        if (stall0) waits++;
        for (int i = 0; i < 12 && !seen0; i++) begin
            step();
            if (s_g0) seen0 = 1;
            else begin
                if (s_g1) beats++;
                if (s_st) waits++;
            end
        end
        chk_b("burst_reached_port0", seen0, 1'b1);
        chk_w("burst_beats", 32'(beats), 32'(MB));
        chk_b("starve_bound", waits <= MB + 1, 1'b1);
        req0 = 1'b0; req1 = 1'b0; lock1 = 1'b0;
        step(); step();

        // Asynchronous reset in the middle of a write beat.
        req1 = 1'b1; we1 = 1'b1; addr1 = 32'h30; wdata1 = 32'h1234_5678;
        step();
        chk_b("arst_pre_gnt1", s_g1, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk_b("arst_we", mem_we, 1'b0);
        chk_b("arst_gnt1", gnt1, 1'b0);
        chk_b("arst_ack1", ack1, 1'b0);
        req1 = 1'b0; we1 = 1'b0;
        step(); step();
        rst_n = 1'b1;
        req0 = 1'b1; req1 = 1'b1;
        step();
        chk_b("arst_tie_port0", s_g0, 1'b1);
        req0 = 1'b0; req1 = 1'b0;
        step(); step();

        // Randomised traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            req0   = ($urandom_range(0, 99) < 55);
            we0    = $urandom_range(0, 1) == 1;
            addr0  = 32'($urandom_range(0, 63));
            wdata0 = $urandom;
            req1   = ($urandom_range(0, 99) < 65);
            we1    = $urandom_range(0, 1) == 1;
            addr1  = 32'($urandom_range(0, 63));
            wdata1 = $urandom;
            lock1  = ($urandom_range(0, 99) < 70);
            step();
        end
        req0 = 1'b0; req1 = 1'b0; lock1 = 1'b0;
        step(); step();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
